branch_resolve_unit: RTL

Pipelined branch resolution unit for the Mk1 CPU. It compares two WIDTH-bit register operands, evaluates a 3-bit branch condition against the lt/eq/gt result, and returns the taken decision and next-PC target. It sits between the register-read stage and the fetch PC mux. It uses valid/ready handshakes on both sides, a flush input for pipeline squash, and a saturating taken-branch counter.

---
 rtl/branch_resolve_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: compare + condition evaluate, producing taken/next-PC with valid/ready flow.
// Optional macro BRU_SIGNED_EN enables two's-complement compares selected per request by in_signed.
module branch_resolve_unit #(
    parameter int WIDTH     = 16,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_cond,
    input  logic                 in_signed,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [PC_WIDTH-1:0]  in_offset,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic [PC_WIDTH-1:0]  out_target,
    output logic [2:0]           out_flags,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                s1_valid;
    logic [2:0]          s1_flags;
    logic [2:0]          s1_cond;
    logic [PC_WIDTH-1:0] s1_pc;
    logic [PC_WIDTH-1:0] s1_offset;

    logic lt, eq, gt;
    logic s2_free;
    logic accept;
    logic cond_taken;
    logic [PC_WIDTH-1:0] next_target;

`ifndef BRU_SIGNED_EN
    logic unused_signed;
    assign unused_signed = in_signed;
`endif

    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        eq = (in_a == in_b);
`ifdef BRU_SIGNED_EN
        if (in_signed) begin
            lt = ($signed(in_a) < $signed(in_b));
            gt = ($signed(in_a) > $signed(in_b));
        end else begin
            lt = (in_a < in_b);
            gt = (in_a > in_b);
        end
`else
        lt = (in_a < in_b);
        gt = (in_a > in_b);
`endif
    end

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = (!s1_valid || s2_free) && !flush;
    assign accept   = in_valid && in_ready;

    // s1_flags is {lt, eq, gt}
    always_comb begin
        cond_taken = 1'b0;
        case (s1_cond)
            3'd0:    cond_taken = s1_flags[1];
            3'd1:    cond_taken = !s1_flags[1];
            3'd2:    cond_taken = s1_flags[2];
            3'd3:    cond_taken = s1_flags[0] || s1_flags[1];
            3'd4:    cond_taken = s1_flags[2] || s1_flags[1];
            3'd5:    cond_taken = s1_flags[0];
            3'd6:    cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    assign next_target = s1_pc + (cond_taken ? s1_offset : PC_WIDTH'(1));

    // S1 drains into S2 whenever S2 can take it; a new request may refill it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_flags  <= 3'b000;
            s1_cond   <= 3'd0;
            s1_pc     <= '0;
            s1_offset <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_flags  <= {lt, eq, gt};
            s1_cond   <= in_cond;
            s1_pc     <= in_pc;
            s1_offset <= in_offset;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    // Output payload only changes when S2 is free, so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_taken  <= 1'b0;
            out_target <= '0;
            out_flags  <= 3'b000;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_taken  <= cond_taken;
                out_target <= next_target;
                out_flags  <= s1_flags;
            end
        end
    end

    // A handshake in a flush cycle has already been seen by the consumer, so it still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
        end else if (out_valid && out_ready && out_taken && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule
